// File: rtl/dpu_mac_feeder.sv
// Operand sequencer for the 2x2 MAC array: buffers weights/activations, issues K
// accumulation steps over a valid/done handshake and publishes the final accumulators.
module dpu_mac_feeder #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [AW:0]        k_len,
  input  logic               wbuf_we,
  input  logic [AW-1:0]      wbuf_addr,
  input  logic [31:0]        wbuf_wdata,
  input  logic               abuf_we,
  input  logic [AW-1:0]      abuf_addr,
  input  logic [15:0]        abuf_wdata,
  output logic               mac_valid,
  output logic signed [7:0]  mac_w00,
  output logic signed [7:0]  mac_w01,
  output logic signed [7:0]  mac_w10,
  output logic signed [7:0]  mac_w11,
  output logic signed [7:0]  mac_a0,
  output logic signed [7:0]  mac_a1,
  output logic signed [31:0] mac_acc0_in,
  output logic signed [31:0] mac_acc1_in,
  input  logic signed [31:0] mac_acc0_out,
  input  logic signed [31:0] mac_acc1_out,
  input  logic               mac_done,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] acc0_res,
  output logic signed [31:0] acc1_res,
  output logic               err
);
  // state  | meaning
  // IDLE   | waiting for start; buffers writable
  // ISSUE  | mac_valid pulse with operands stable
  // WAIT   | waiting for mac_done, timeout counter running
  // FINISH | done pulse; acc*_res already hold the results
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT);

  logic [1:0]         state;
  logic [AW:0]        k_reg;
  logic [AW:0]        idx;
  logic [AW:0]        idx_nxt;
  logic [AW:0]        k_eff;
  logic [TW-1:0]      tcnt;
  logic signed [31:0] acc0;
  logic signed [31:0] acc1;
  logic [AW-1:0]      rd_addr;
  logic [31:0]        rd_w;
  logic [15:0]        rd_a;

  logic [31:0] wbuf [DEPTH];
  logic [15:0] abuf [DEPTH];

  // Register files are not reset; writes land only while idle.
  always_ff @(posedge clk) begin
    if (wbuf_we && state == S_IDLE) wbuf[wbuf_addr] <= wbuf_wdata;
    if (abuf_we && state == S_IDLE) abuf[abuf_addr] <= abuf_wdata;
  end

  assign k_eff   = (k_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : k_len;
  assign idx_nxt = idx + (AW+1)'(1);

  always_comb begin
    rd_addr = '0;
    if (state == S_WAIT) rd_addr = idx_nxt[AW-1:0];
  end

  assign rd_w = wbuf[rd_addr];
  assign rd_a = abuf[rd_addr];

  assign mac_valid = (state == S_ISSUE);
  assign done      = (state == S_FINISH);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      k_reg       <= '0;
      idx         <= '0;
      tcnt        <= '0;
      acc0        <= '0;
      acc1        <= '0;
      mac_w00     <= '0;
      mac_w01     <= '0;
      mac_w10     <= '0;
      mac_w11     <= '0;
      mac_a0      <= '0;
      mac_a1      <= '0;
      mac_acc0_in <= '0;
      mac_acc1_in <= '0;
      acc0_res    <= '0;
      acc1_res    <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k_reg <= k_eff;
            idx   <= '0;
            acc0  <= '0;
            acc1  <= '0;
            err   <= 1'b0;
            if (k_eff == '0) begin
              acc0_res <= '0;
              acc1_res <= '0;
              state    <= S_FINISH;
            end else begin
              mac_w00     <= $signed(rd_w[7:0]);
              mac_w01     <= $signed(rd_w[15:8]);
              mac_w10     <= $signed(rd_w[23:16]);
              mac_w11     <= $signed(rd_w[31:24]);
              mac_a0      <= $signed(rd_a[7:0]);
              mac_a1      <= $signed(rd_a[15:8]);
              mac_acc0_in <= '0;
              mac_acc1_in <= '0;
              state       <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          tcnt  <= TO_LOAD;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mac_done) begin
            acc0 <= mac_acc0_out;
            acc1 <= mac_acc1_out;
            idx  <= idx_nxt;
            if (idx_nxt == k_reg) begin
              acc0_res <= mac_acc0_out;
              acc1_res <= mac_acc1_out;
              state    <= S_FINISH;
            end else begin
              mac_w00     <= $signed(rd_w[7:0]);
              mac_w01     <= $signed(rd_w[15:8]);
              mac_w10     <= $signed(rd_w[23:16]);
              mac_w11     <= $signed(rd_w[31:24]);
              mac_a0      <= $signed(rd_a[7:0]);
              mac_a1      <= $signed(rd_a[15:8]);
              mac_acc0_in <= mac_acc0_out;
              mac_acc1_in <= mac_acc1_out;
              state       <= S_ISSUE;
            end
          end else if (tcnt == '0) begin
            // Timed out: publish whatever has accumulated so far.
            err      <= 1'b1;
            acc0_res <= acc0;
            acc1_res <= acc1;
            state    <= S_FINISH;
          end else begin
            tcnt <= tcnt - TW'(1);
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpu_mac_feeder.sv
// Self-checking bench for dpu_mac_feeder: bench-side MAC responder plus a reference
// model built from shadow buffer contents (prefix sums of the dot products).
module tb_dpu_mac_feeder;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [4:0]         k_len = '0;
  logic               wbuf_we = 1'b0;
  logic [3:0]         wbuf_addr = '0;
  logic [31:0]        wbuf_wdata = '0;
  logic               abuf_we = 1'b0;
  logic [3:0]         abuf_addr = '0;
  logic [15:0]        abuf_wdata = '0;
  logic               mac_valid;
  logic signed [7:0]  mac_w00, mac_w01, mac_w10, mac_w11, mac_a0, mac_a1;
  logic signed [31:0] mac_acc0_in, mac_acc1_in;
  logic signed [31:0] mac_acc0_out = '0;
  logic signed [31:0] mac_acc1_out = '0;
  logic               mac_done = 1'b0;
  logic               busy, done, err;
  logic signed [31:0] acc0_res, acc1_res;

  dpu_mac_feeder #(.DEPTH(16), .AW(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .wbuf_we(wbuf_we), .wbuf_addr(wbuf_addr), .wbuf_wdata(wbuf_wdata),
    .abuf_we(abuf_we), .abuf_addr(abuf_addr), .abuf_wdata(abuf_wdata),
    .mac_valid(mac_valid), .mac_w00(mac_w00), .mac_w01(mac_w01),
    .mac_w10(mac_w10), .mac_w11(mac_w11), .mac_a0(mac_a0), .mac_a1(mac_a1),
    .mac_acc0_in(mac_acc0_in), .mac_acc1_in(mac_acc1_in),
    .mac_acc0_out(mac_acc0_out), .mac_acc1_out(mac_acc1_out), .mac_done(mac_done),
    .busy(busy), .done(done), .acc0_res(acc0_res), .acc1_res(acc1_res), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] wmem [16];
  logic [15:0] amem [16];
  int pre0 [17];
  int pre1 [17];
  int acc0_log [16];
  int acc1_log [16];

  int cyc, vcnt, exp_cyc, exp_valids;
  int exp_r0, exp_r1;
  bit exp_err, mon_on = 0, got_done = 0, resp_en = 0;
  int lat_min = 1, lat_max = 1;
  bit pend = 0;
  int lat_cnt = 0;
  int r0, r1;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int s8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // MAC array stand-in plus the per-cycle compare process.
  always @(negedge clk) begin
    mac_done = 1'b0;
    if (!rst_n) pend = 0;
    else if (pend) begin
      if (lat_cnt <= 1) begin
        mac_done = 1'b1;
        mac_acc0_out = r0;
        mac_acc1_out = r1;
        pend = 0;
      end else lat_cnt--;
    end
    if (rst_n && mac_valid && resp_en) begin
      pend = 1;
      lat_cnt = int'($urandom_range(lat_max, lat_min));
      r0 = int'(mac_acc0_in) + int'(mac_w00) * int'(mac_a0) + int'(mac_w01) * int'(mac_a1);
      r1 = int'(mac_acc1_in) + int'(mac_w10) * int'(mac_a0) + int'(mac_w11) * int'(mac_a1);
    end
    if (mon_on) begin
      cyc++;
      chk("busy_in_run", busy, 1);
      if (cyc == 1) chk("err_cleared_on_start", err, 0);
      if (mac_valid) begin
        if (vcnt < 16) begin
          chk("operands", {mac_w11, mac_w10, mac_w01, mac_w00, mac_a1, mac_a0},
              {wmem[vcnt], amem[vcnt]});
          chk("acc0_in", mac_acc0_in, pre0[vcnt]);
          chk("acc1_in", mac_acc1_in, pre1[vcnt]);
          acc0_log[vcnt] = mac_acc0_in;
          acc1_log[vcnt] = mac_acc1_in;
        end else chk("valid_overrun", vcnt, 15);
        vcnt++;
      end
      if (done) begin
        if (exp_cyc >= 0) chk("done_cycle", cyc, exp_cyc);
        chk("valid_count", vcnt, exp_valids);
        chk("acc0_res", acc0_res, exp_r0);
        chk("acc1_res", acc1_res, exp_r1);
        chk("err_at_done", err, exp_err);
        got_done = 1;
        mon_on = 0;
      end
    end
  end

  task automatic wr(input int i, input logic [31:0] w, input logic [15:0] a);
    @(negedge clk);
    wbuf_we = 1; wbuf_addr = 4'(i); wbuf_wdata = w;
    abuf_we = 1; abuf_addr = 4'(i); abuf_wdata = a;
    @(negedge clk);
    wbuf_we = 0; abuf_we = 0;
    wmem[i] = w;
    amem[i] = a;
  endtask

  task automatic prep(input int k, input int lmin, input int lmax, input bit resp,
                      input int ecyc, input bit eerr);
    int kk;
    kk = (k > 16) ? 16 : k;
    pre0[0] = 0;
    pre1[0] = 0;
    for (int i = 0; i < 16; i++) begin
      pre0[i+1] = pre0[i] + s8(wmem[i][7:0]) * s8(amem[i][7:0]) + s8(wmem[i][15:8]) * s8(amem[i][15:8]);
      pre1[i+1] = pre1[i] + s8(wmem[i][23:16]) * s8(amem[i][7:0]) + s8(wmem[i][31:24]) * s8(amem[i][15:8]);
    end
    exp_valids = eerr ? 1 : kk;
    exp_r0 = eerr ? 0 : pre0[kk];
    exp_r1 = eerr ? 0 : pre1[kk];
    exp_cyc = ecyc;
    exp_err = eerr;
    resp_en = resp;
    lat_min = lmin;
    lat_max = lmax;
  endtask

  task automatic start_run(input int k);
    @(negedge clk);
    start = 1;
    k_len = 5'(k);
    @(posedge clk);
    cyc = 0;
    vcnt = 0;
    got_done = 0;
    mon_on = 1;
    #1 start = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !got_done; i++) @(negedge clk);
    chk("done_seen", got_done, 1);
    mon_on = 0;
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
  endtask

  task automatic run(input int k, input int lmin, input int lmax, input bit resp,
                     input int ecyc, input bit eerr);
    prep(k, lmin, lmax, resp, ecyc, eerr);
    start_run(k);
    wait_done();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, mac_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ops"}, {mac_w11, mac_w10, mac_w01, mac_w00, mac_a1, mac_a0}, 0);
    chk({tag, "_accin"}, {mac_acc1_in, mac_acc0_in}, 0);
    chk({tag, "_res"}, {acc1_res, acc0_res}, 0);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 16; i++) begin wmem[i] = '0; amem[i] = '0; end
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1;

    // Single step, hand-computed result.
    wr(0, 32'h04030201, 16'h0605);
    run(1, 1, 1, 1, 3, 0);
    chk("t1_acc0_lit", acc0_res, 17);
    chk("t1_acc1_lit", acc1_res, 39);

    // Four steps of -1 each.
    for (int i = 0; i < 4; i++) wr(i, 32'h01010101, 16'h7F80);
    run(4, 1, 1, 1, 9, 0);
    chk("t2_acc0_lit", acc0_res, -4);
    chk("t2_acc1_lit", acc1_res, -4);
    chk("t2_accin0_lit", acc0_log[0], 0);
    chk("t2_accin1_lit", acc0_log[1], -1);
    chk("t2_accin2_lit", acc1_log[2], -2);
    chk("t2_accin3_lit", acc1_log[3], -3);

    run(0, 1, 1, 1, 1, 0);
    chk("k0_res_lit", {acc1_res, acc0_res}, 0);

    // Full depth with random data and random latency, then clamped k_len.
    for (int i = 0; i < 16; i++) wr(i, $urandom, 16'($urandom));
    run(16, 1, 5, 1, -1, 0);
    run(20, 1, 1, 1, 33, 0);

    // Timeout, then a fresh start clears err.
    run(2, 1, 1, 0, 258, 1);
    chk("to_err_held", err, 1);
    run(1, 2, 2, 1, 4, 0);
    chk("to_err_cleared", err, 0);

    // start and buffer writes while busy are dropped.
    fork
      run(4, 2, 2, 1, 13, 0);
      begin
        repeat (4) @(negedge clk);
        start = 1; k_len = 5'd0;
        wbuf_we = 1; wbuf_addr = 4'd0; wbuf_wdata = 32'hDEADBEEF;
        abuf_we = 1; abuf_addr = 4'd1; abuf_wdata = 16'hBEEF;
        @(negedge clk);
        start = 0; wbuf_we = 0; abuf_we = 0;
      end
    join
    repeat (3) begin
      @(negedge clk);
      chk("idle_quiet", {busy, mac_valid, done}, 0);
    end
    run(4, 1, 1, 1, 9, 0);

    // Reset during the wait of step 2, then a clean rerun.
    prep(4, 1, 1, 1, 9, 0);
    start_run(4);
    guard = 0;
    while (vcnt < 2 && guard < 40) begin @(posedge clk); guard++; end
    chk("rst_reached_step2", vcnt, 2);
    #1 rst_n = 0;
    mon_on = 0;
    #1 chk_reset_vals("midrun_rst");
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    rst_n = 1;
    run(4, 1, 1, 1, 9, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
